// File: rtl/assert_stream_checker.sv
// Scans a console byte stream for ":assert:(<v>)" records and reports each
// record as a pass/fail event with saturating counters and a sticky ERROR.
module assert_stream_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             res_valid,
    output logic             res_pass,
    input  logic             res_ready,
    output logic             ERROR,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    typedef enum logic [3:0] {
        M0, M1, M2, M3, M4, M5, M6, M7, M8, VAL, CLOSE
    } state_t;

    state_t state, state_n, fb;
    logic   lat, lat_n;
    logic   accept, done, bad;

    function automatic logic [7:0] pat(input state_t s);
        case (s)
            M0:      pat = ":";
            M1:      pat = "a";
            M2:      pat = "s";
            M3:      pat = "s";
            M4:      pat = "e";
            M5:      pat = "r";
            M6:      pat = "t";
            M7:      pat = ":";
            M8:      pat = "(";
            default: pat = 8'h00;
        endcase
    endfunction

    assign in_ready = !res_valid || res_ready;
    assign accept   = in_valid && in_ready;
    // A ':' can always start a fresh record, so fall back past it.
    assign fb       = (in_data == ":") ? M1 : M0;

    always_comb begin
        state_n = state;
        lat_n   = lat;
        done    = 1'b0;
        bad     = 1'b0;
        if (accept) begin
            case (state)
                VAL: begin
                    if (in_data inside {"1", "0", "x", "X", "z", "Z"}) begin
                        lat_n   = (in_data == "1");
                        state_n = CLOSE;
                    end else begin
                        bad     = 1'b1;
                        state_n = fb;
                    end
                end
                CLOSE: begin
                    if (in_data == ")") begin
                        done    = 1'b1;
                        state_n = M0;
                    end else begin
                        bad     = 1'b1;
                        state_n = fb;
                    end
                end
                default: begin
                    if (in_data == pat(state))
                        state_n = state_t'(state + 4'd1);
                    else
                        state_n = fb;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= M0;
            lat   <= 1'b0;
        end else begin
            state <= state_n;
            lat   <= lat_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_pass  <= 1'b0;
            ERROR     <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            if (res_valid && res_ready)
                res_valid <= 1'b0;
            if (done) begin
                res_valid <= 1'b1;
                res_pass  <= lat;
                if (lat) begin
                    if (pass_cnt != {CNT_W{1'b1}})
                        pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    ERROR <= 1'b1;
                    if (fail_cnt != {CNT_W{1'b1}})
                        fail_cnt <= fail_cnt + 1'b1;
                end
            end
            if (bad && bad_cnt != {CNT_W{1'b1}})
                bad_cnt <= bad_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_assert_stream_checker.sv
// Bench for assert_stream_checker: record table, scoreboard of expected
// events, backpressure, mid-record reset and narrow-counter saturation.
module tb_assert_stream_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv0, iv1, ir0, ir1, rv0, rv1, rp0, rp1, rr0, rr1, er0, er1;
    logic [7:0]  id0, id1;
    logic [15:0] pc0, fc0, bc0;
    logic [1:0]  pc1, fc1, bc1;

    assert_stream_checker #(.CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_data(id0),
        .in_ready(ir0), .res_valid(rv0), .res_pass(rp0),
        .res_ready(rr0), .ERROR(er0), .pass_cnt(pc0),
        .fail_cnt(fc0), .bad_cnt(bc0)
    );

    assert_stream_checker #(.CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_data(id1),
        .in_ready(ir1), .res_valid(rv1), .res_pass(rp1),
        .res_ready(rr1), .ERROR(er1), .pass_cnt(pc1),
        .fail_cnt(fc1), .bad_cnt(bc1)
    );

    int total  = 0;
    int passed = 0;
    int q0[$];
    int q1[$];
    int nev1 = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard: compare each consumed event against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rv0 && rr0) begin
            if (q0.size() == 0) chk("u0 unexpected event", 1, 0);
            else chk("u0 res_pass", rp0, q0.pop_front());
        end
        if (!rst && rv1 && rr1) begin
            nev1++;
            if (q1.size() == 0) chk("u1 unexpected event", 1, 0);
            else chk("u1 res_pass", rp1, q1.pop_front());
        end
    end

    task automatic send_char(input int d, input byte c);
        int t;
        if (d == 0) begin iv0 = 1'b1; id0 = c; end
        else begin iv1 = 1'b1; id1 = c; end
        t = 0;
        while (!((d == 0) ? ir0 : ir1) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("in_ready timeout", 0, 1);
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        iv1 = 1'b0;
    endtask

    task automatic send_str(input int d, input string s, input int ev);
        if (ev >= 0) begin
            if (d == 0) q0.push_back(ev);
            else q1.push_back(ev);
        end
        for (int i = 0; i < s.len(); i++) send_char(d, s[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit    rst_first;
        string txt;
        int    ev;
        int    pc;
        int    fc;
        int    bc;
        int    err;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{0, ":assert:(0)",            0, 1, 1, 0, 1};
        tbl[1] = '{0, ":assert:(x)",            0, 1, 2, 0, 1};
        tbl[2] = '{0, ":assert:(1)",            1, 2, 2, 0, 1};
        tbl[3] = '{1, "::assert:(1)",           1, 1, 0, 0, 0};
        tbl[4] = '{0, ":assert:(2)",           -1, 1, 0, 1, 0};
        tbl[5] = '{0, ":assert:(1]",           -1, 1, 0, 2, 0};
        tbl[6] = '{0, "noise :as:assert:(X)",   0, 1, 1, 2, 1};
        tbl[7] = '{0, "::(:assert:(z))",        0, 1, 2, 2, 1};
        tbl[8] = '{0, ":assert:(:assert:(1)",   1, 2, 2, 3, 1};

        rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0; id0 = '0; id1 = '0;
        rr0 = 1'b1; rr1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset in_ready", ir0, 1);
        chk("reset res_valid", rv0, 0);
        chk("reset res_pass", rp0, 0);
        chk("reset ERROR", er0, 0);
        chk("reset counters", {pc0, fc0, bc0}, 0);

        // Single pass record: event exactly one cycle after ')'.
        send_str(0, ":assert:(1", 1);
        chk("pre-close res_valid", rv0, 0);
        send_char(0, ")");
        chk("latency res_valid", rv0, 1);
        chk("latency res_pass", rp0, 1);
        chk("latency pass_cnt", pc0, 1);
        @(posedge clk); #1;
        chk("pulse once res_valid", rv0, 0);
        chk("first ERROR", er0, 0);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst_first) do_reset();
            send_str(0, tbl[i].txt, tbl[i].ev);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("row%0d pass_cnt", i), pc0, tbl[i].pc);
            chk($sformatf("row%0d fail_cnt", i), fc0, tbl[i].fc);
            chk($sformatf("row%0d bad_cnt", i), bc0, tbl[i].bc);
            chk($sformatf("row%0d ERROR", i), er0, tbl[i].err);
        end

        // Backpressure: second record must stall, not drop characters.
        rr0 = 1'b0;
        fork
            begin
                send_str(0, ":assert:(1)", 1);
                send_str(0, ":assert:(0)", 0);
            end
        join_none
        repeat (20) @(posedge clk);
        #1;
        chk("stall in_ready", ir0, 0);
        chk("stall res_valid", rv0, 1);
        chk("stall res_pass", rp0, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("stall in_ready held", ir0, 0);
        rr0 = 1'b1;
        wait fork;
        repeat (3) @(posedge clk);
        #1;
        chk("bp pass_cnt", pc0, 3);
        chk("bp fail_cnt", fc0, 3);
        chk("bp bad_cnt", bc0, 3);

        // Reset mid-record discards the partial match.
        send_str(0, ":asse", -1);
        do_reset();
        send_str(0, "rt:(0))", -1);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst res_valid", rv0, 0);
        chk("midrst ERROR", er0, 0);
        chk("midrst counters", {pc0, fc0, bc0}, 0);

        // Narrow counters saturate but events keep flowing.
        nev1 = 0;
        for (int i = 0; i < 5; i++) send_str(1, ":assert:(1)", 1);
        repeat (3) @(posedge clk);
        #1;
        chk("sat pass_cnt", pc1, 3);
        chk("sat events", nev1, 5);
        chk("sat ERROR clear", er1, 0);
        for (int i = 0; i < 4; i++) send_str(1, ":assert:(0)", 0);
        repeat (3) @(posedge clk);
        #1;
        chk("sat fail_cnt", fc1, 3);
        chk("sat fail events", nev1, 9);
        chk("sat ERROR", er1, 1);

        for (int t = 0; t < 100 && (q0.size() + q1.size()) != 0; t++)
            @(posedge clk);
        chk("u0 events drained", q0.size(), 0);
        chk("u1 events drained", q1.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
